// File: rtl/controller_fsm.sv
// Multicycle RV32I control unit: a state register walks each instruction from FETCH,
// and every datapath select/enable is decoded combinationally from the state and instruction fields.
module controller_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] Flags,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [3:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [2:0] LoadType,
  output logic [1:0] StoreType,
  output logic       Illegal,
  output logic       Retire,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_UIMM     = 4'd13,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  state_t state_q, state_d;
  logic   branch_taken;

  // ALU operation for R/I-type; alt selects sub/sra where the encoding has a variant
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_decode = alt ? 4'b0001 : 4'b0000;
      3'b001:  alu_decode = 4'b0111;
      3'b010:  alu_decode = 4'b0101;
      3'b011:  alu_decode = 4'b0110;
      3'b100:  alu_decode = 4'b0100;
      3'b101:  alu_decode = alt ? 4'b1001 : 4'b1000;
      3'b110:  alu_decode = 4'b0011;
      default: alu_decode = 4'b0010;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UIMM;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL, S_JALRPC, S_UIMM: state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRPC;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Flags = {N,Z,C,V}; C=1 means no borrow
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = Flags[2];
      3'b001:  branch_taken = ~Flags[2];
      3'b100:  branch_taken = Flags[3] ^ Flags[0];
      3'b101:  branch_taken = ~(Flags[3] ^ Flags[0]);
      3'b110:  branch_taken = ~Flags[1];
      3'b111:  branch_taken = Flags[1];
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    ImmSrc     = IMM_I;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    ALUControl = ALU_ADD;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    LoadType   = 3'b000;
    StoreType  = 2'b00;
    Illegal    = 1'b0;
    Retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1; LoadType = funct3;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01; RegWrite = 1'b1; Retire = 1'b1; LoadType = funct3;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1; MemWrite = 1'b1; Retire = 1'b1; StoreType = funct3[1:0];
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10; ALUControl = alu_decode(funct3, funct7b5);
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10; ALUSrcB = 2'b01;
        ALUControl = alu_decode(funct3, (funct3 != 3'b000) && funct7b5);
      end
      S_ALUWB: begin
        RegWrite = 1'b1; Retire = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10; ALUControl = ALU_SUB; Retire = 1'b1; PCWrite = branch_taken;
      end
      S_JAL, S_JALRPC: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
      end
      S_UIMM: begin
        ImmSrc  = IMM_U; ALUSrcB = 2'b01;
        ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
      end
      S_ILLEGAL: Illegal = 1'b1;
      default: ;
    endcase
    // Reset abandons any partial instruction without side effects
    if (!reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Retire   = 1'b0;
      Illegal  = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_controller_fsm.sv
// Directed bench for controller_fsm: walks each instruction class through its state
// sequence and compares decoded controls against hand-derived values.
module tb_controller_fsm;

  logic       clock;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [3:0] Flags;
  logic [2:0] ImmSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc;
  logic [3:0] ALUControl;
  logic       IRWrite, PCWrite, RegWrite, MemWrite;
  logic [2:0] LoadType;
  logic [1:0] StoreType;
  logic       Illegal, Retire;
  logic [3:0] State;

  int errors = 0;
  int checks = 0;

  controller_fsm dut (
    .clock(clock), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Flags(Flags), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .LoadType(LoadType), .StoreType(StoreType), .Illegal(Illegal), .Retire(Retire),
    .State(State)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle; also checks write-enable exclusivity every cycle
  task automatic tick();
    @(posedge clock);
    #1;
    checks++;
    if ($countones({RegWrite, MemWrite, IRWrite}) > 1) begin
      errors++; $display("FAIL write_exclusive state=%0d got=%b exp=at_most_one", State, {RegWrite, MemWrite, IRWrite});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Flags = 4'b0;
    tick();
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", State); end
    checks++; if ({IRWrite, PCWrite, RegWrite, MemWrite, Retire, Illegal} !== 6'b0) begin
      errors++; $display("FAIL reset_enables got=%b exp=000000", {IRWrite, PCWrite, RegWrite, MemWrite, Retire, Illegal}); end
    reset = 1'b1; #1;
    checks++; if ({IRWrite, PCWrite, ALUSrcB, ResultSrc} !== 6'b11_10_10) begin
      errors++; $display("FAIL fetch_controls got=%b exp=111010", {IRWrite, PCWrite, ALUSrcB, ResultSrc}); end
  endtask

  task automatic test_add();
    int retires;
    retires = 0;
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    tick();
    checks++; if ({State, ALUSrcA, ALUSrcB, ImmSrc} !== {4'd1, 2'b01, 2'b01, 3'b010}) begin
      errors++; $display("FAIL add_decode got=%b exp=%b", {State, ALUSrcA, ALUSrcB, ImmSrc}, {4'd1, 2'b01, 2'b01, 3'b010}); end
    tick();
    checks++; if ({State, ALUControl, ALUSrcA, ALUSrcB, RegWrite} !== {4'd6, 4'b0000, 2'b10, 2'b00, 1'b0}) begin
      errors++; $display("FAIL add_execr got=%b exp=%b", {State, ALUControl, ALUSrcA, ALUSrcB, RegWrite}, {4'd6, 4'b0000, 2'b10, 2'b00, 1'b0}); end
    funct7b5 = 1'b1; #1;
    checks++; if (ALUControl !== 4'b0001) begin errors++; $display("FAIL sub_alu got=%b exp=0001", ALUControl); end
    funct3 = 3'b101; #1;
    checks++; if (ALUControl !== 4'b1001) begin errors++; $display("FAIL sra_alu got=%b exp=1001", ALUControl); end
    funct3 = 3'b111; #1;
    checks++; if (ALUControl !== 4'b0010) begin errors++; $display("FAIL and_alu got=%b exp=0010", ALUControl); end
    funct3 = 3'b000; funct7b5 = 1'b0;
    tick();
    retires += int'(Retire);
    checks++; if ({State, RegWrite, ResultSrc} !== {4'd8, 1'b1, 2'b00}) begin
      errors++; $display("FAIL add_aluwb got=%b exp=%b", {State, RegWrite, ResultSrc}, {4'd8, 1'b1, 2'b00}); end
    tick();
    retires += int'(Retire);
    checks++; if (State !== 4'd0 || retires != 1) begin
      errors++; $display("FAIL add_end state=%0d retires=%0d exp state=0 retires=1", State, retires); end
  endtask

  task automatic test_itype();
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick(); tick();
    checks++; if ({State, ALUControl, ALUSrcB, ImmSrc} !== {4'd7, 4'b0000, 2'b01, 3'b000}) begin
      errors++; $display("FAIL addi_exec got=%b exp=%b", {State, ALUControl, ALUSrcB, ImmSrc}, {4'd7, 4'b0000, 2'b01, 3'b000}); end
    funct3 = 3'b101; #1;
    checks++; if (ALUControl !== 4'b1001) begin errors++; $display("FAIL srai_alu got=%b exp=1001", ALUControl); end
    funct3 = 3'b011; #1;
    checks++; if (ALUControl !== 4'b0110) begin errors++; $display("FAIL sltiu_alu got=%b exp=0110", ALUControl); end
    tick(); tick();
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL addi_end got=%0d exp=0", State); end
  endtask

  task automatic test_lw();
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    checks++; if (LoadType !== 3'b000) begin errors++; $display("FAIL lw_fetch_loadtype got=%b exp=000", LoadType); end
    tick(); tick();
    checks++; if ({State, ImmSrc, ALUSrcA, ALUSrcB} !== {4'd2, 3'b000, 2'b10, 2'b01}) begin
      errors++; $display("FAIL lw_memadr got=%b exp=%b", {State, ImmSrc, ALUSrcA, ALUSrcB}, {4'd2, 3'b000, 2'b10, 2'b01}); end
    tick();
    checks++; if ({State, LoadType, AdrSrc, ResultSrc, RegWrite} !== {4'd3, 3'b010, 1'b1, 2'b00, 1'b0}) begin
      errors++; $display("FAIL lw_memread got=%b exp=%b", {State, LoadType, AdrSrc, ResultSrc, RegWrite}, {4'd3, 3'b010, 1'b1, 2'b00, 1'b0}); end
    tick();
    checks++; if ({State, LoadType, ResultSrc, RegWrite, Retire} !== {4'd4, 3'b010, 2'b01, 1'b1, 1'b1}) begin
      errors++; $display("FAIL lw_memwb got=%b exp=%b", {State, LoadType, ResultSrc, RegWrite, Retire}, {4'd4, 3'b010, 2'b01, 1'b1, 1'b1}); end
    tick();
    checks++; if ({State, LoadType} !== {4'd0, 3'b000}) begin errors++; $display("FAIL lw_end got=%b exp=%b", {State, LoadType}, {4'd0, 3'b000}); end
  endtask

  task automatic test_sw();
    op = 7'b0100011; funct3 = 3'b010;
    tick(); tick();
    checks++; if ({State, ImmSrc} !== {4'd2, 3'b001}) begin errors++; $display("FAIL sw_memadr got=%b exp=%b", {State, ImmSrc}, {4'd2, 3'b001}); end
    tick();
    checks++; if ({State, MemWrite, StoreType, AdrSrc, RegWrite, Retire} !== {4'd5, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sw_memwrite got=%b exp=%b", {State, MemWrite, StoreType, AdrSrc, RegWrite, Retire}, {4'd5, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1}); end
    tick();
    checks++; if ({State, MemWrite, StoreType} !== {4'd0, 1'b0, 2'b00}) begin
      errors++; $display("FAIL sw_end got=%b exp=%b", {State, MemWrite, StoreType}, {4'd0, 1'b0, 2'b00}); end
  endtask

  task automatic test_branch();
    op = 7'b1100011; funct3 = 3'b000; Flags = 4'b0100;
    tick(); tick();
    checks++; if ({State, PCWrite, ALUControl, Retire} !== {4'd9, 1'b1, 4'b0001, 1'b1}) begin
      errors++; $display("FAIL beq_taken got=%b exp=%b", {State, PCWrite, ALUControl, Retire}, {4'd9, 1'b1, 4'b0001, 1'b1}); end
    Flags = 4'b0000; #1;
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL beq_not_taken got=%b exp=0", PCWrite); end
    funct3 = 3'b110; Flags = 4'b0000; #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL bltu_c0 got=%b exp=1", PCWrite); end
    Flags = 4'b0010; #1;
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL bltu_c1 got=%b exp=0", PCWrite); end
    funct3 = 3'b100; Flags = 4'b1000; #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL blt_nxv got=%b exp=1", PCWrite); end
    Flags = 4'b1001; #1;
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL blt_n_eq_v got=%b exp=0", PCWrite); end
    funct3 = 3'b011; Flags = 4'b1111; #1;
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL branch_f3_011 got=%b exp=0", PCWrite); end
    tick();
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL branch_end got=%0d exp=0", State); end
    Flags = 4'b0000;
  endtask

  task automatic test_jal();
    op = 7'b1101111; funct3 = 3'b000;
    tick();
    checks++; if ({State, ImmSrc} !== {4'd1, 3'b011}) begin errors++; $display("FAIL jal_decode got=%b exp=%b", {State, ImmSrc}, {4'd1, 3'b011}); end
    tick();
    checks++; if ({State, PCWrite, ALUSrcA, ALUSrcB, RegWrite} !== {4'd10, 1'b1, 2'b01, 2'b10, 1'b0}) begin
      errors++; $display("FAIL jal_state got=%b exp=%b", {State, PCWrite, ALUSrcA, ALUSrcB, RegWrite}, {4'd10, 1'b1, 2'b01, 2'b10, 1'b0}); end
    tick();
    checks++; if ({State, RegWrite, Retire} !== {4'd8, 1'b1, 1'b1}) begin errors++; $display("FAIL jal_aluwb got=%b exp=%b", {State, RegWrite, Retire}, {4'd8, 1'b1, 1'b1}); end
    tick();
  endtask

  task automatic test_jalr();
    op = 7'b1100111;
    tick(); tick();
    checks++; if ({State, ALUSrcA, ALUSrcB, ImmSrc, PCWrite} !== {4'd11, 2'b10, 2'b01, 3'b000, 1'b0}) begin
      errors++; $display("FAIL jalr_state got=%b exp=%b", {State, ALUSrcA, ALUSrcB, ImmSrc, PCWrite}, {4'd11, 2'b10, 2'b01, 3'b000, 1'b0}); end
    tick();
    checks++; if ({State, ALUSrcA, ALUSrcB, PCWrite} !== {4'd12, 2'b01, 2'b10, 1'b1}) begin
      errors++; $display("FAIL jalrpc_state got=%b exp=%b", {State, ALUSrcA, ALUSrcB, PCWrite}, {4'd12, 2'b01, 2'b10, 1'b1}); end
    tick();
    checks++; if ({State, RegWrite} !== {4'd8, 1'b1}) begin errors++; $display("FAIL jalr_aluwb got=%b exp=%b", {State, RegWrite}, {4'd8, 1'b1}); end
    tick();
  endtask

  task automatic test_uimm();
    op = 7'b0110111;
    tick(); tick();
    checks++; if ({State, ImmSrc, ALUSrcA, ALUSrcB} !== {4'd13, 3'b100, 2'b11, 2'b01}) begin
      errors++; $display("FAIL lui_state got=%b exp=%b", {State, ImmSrc, ALUSrcA, ALUSrcB}, {4'd13, 3'b100, 2'b11, 2'b01}); end
    op = 7'b0010111; #1;
    checks++; if (ALUSrcA !== 2'b01) begin errors++; $display("FAIL auipc_srca got=%b exp=01", ALUSrcA); end
    tick(); tick();
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL uimm_end got=%0d exp=0", State); end
  endtask

  task automatic test_illegal();
    op = 7'b0000000;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      checks++; if ({State, Illegal, IRWrite, PCWrite} !== {4'd15, 1'b1, 1'b0, 1'b0}) begin
        errors++; $display("FAIL illegal_hold cyc=%0d got=%b exp=%b", i, {State, Illegal, IRWrite, PCWrite}, {4'd15, 1'b1, 1'b0, 1'b0}); end
      tick();
    end
    reset = 1'b0; #1;
    checks++; if (Illegal !== 1'b0) begin errors++; $display("FAIL illegal_reset_comb got=%b exp=0", Illegal); end
    tick();
    reset = 1'b1; #1;
    checks++; if ({State, Illegal, IRWrite} !== {4'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL illegal_recover got=%b exp=%b", {State, Illegal, IRWrite}, {4'd0, 1'b0, 1'b1}); end
  endtask

  task automatic test_reset_midinstr();
    op = 7'b0100011; funct3 = 3'b001;
    tick(); tick();
    checks++; if (State !== 4'd2) begin errors++; $display("FAIL mid_reach_memadr got=%0d exp=2", State); end
    reset = 1'b0;
    tick();
    checks++; if ({State, MemWrite, Retire} !== {4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset got=%b exp=%b", {State, MemWrite, Retire}, {4'd0, 1'b0, 1'b0}); end
    reset = 1'b1;
    tick();
    checks++; if (State !== 4'd1) begin errors++; $display("FAIL mid_restart got=%0d exp=1", State); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_itype();
    test_lw();
    test_sw();
    test_branch();
    test_jal();
    test_jalr();
    test_uimm();
    test_illegal();
    test_reset_midinstr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
